// File: rtl/prg_ram_injector.sv
// prg_ram_injector: strips the PRG load-address header and writes the payload into main RAM.
// Optional PRG_BASIC_PTR_EN: after the payload, patch VARTAB/ARYTAB/STREND with the end address.
module prg_ram_injector #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [7:0]  PTR_BASE    = 8'h2D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        load_prg,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic        ram_ack,
    output logic        busy,
    output logic        done,
    output logic [15:0] end_addr,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
`ifdef PRG_BASIC_PTR_EN
        PTR,
`endif
        FIN
    } state_t;

`ifdef PRG_BASIC_PTR_EN
    localparam state_t EXIT = PTR;
`else
    localparam state_t EXIT = FIN;
`endif

    localparam logic [31:0] TMO_LAST = ACK_TIMEOUT - 1;

    state_t      state_q;
    logic        sess_q;
    logic        wrote_q;
    logic [15:0] load_q;
    logic [31:0] tmo_q;
`ifdef PRG_BASIC_PTR_EN
    logic [2:0]  ptr_idx_q;
`endif

    logic        sess_d;
    logic        wr_ok_d;
    logic [23:0] tgt_d;
    logic        wrap_d;
    logic        tmo_hit_d;

    assign sess_d    = ioctl_download & load_prg;
    assign wr_ok_d   = ioctl_wr & sess_d;
    // 24-bit sum so anything past $FFFF (or an offset below 2) shows in the top byte
    assign tgt_d     = {8'h00, load_q} + {1'b0, ioctl_addr} - 24'd2;
    assign wrap_d    = tgt_d[23:16] != 8'h00;
    assign tmo_hit_d = (ACK_TIMEOUT != 0) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sess_q     <= 1'b0;
            wrote_q    <= 1'b0;
            load_q     <= '0;
            tmo_q      <= '0;
            ioctl_wait <= 1'b0;
            ram_addr   <= '0;
            ram_dout   <= '0;
            ram_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            end_addr   <= '0;
            err        <= 1'b0;
`ifdef PRG_BASIC_PTR_EN
            ptr_idx_q  <= '0;
`endif
        end else begin
            sess_q <= sess_d;
            done   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sess_d && !sess_q) begin
                        state_q   <= HDR;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        wrote_q   <= 1'b0;
`ifdef PRG_BASIC_PTR_EN
                        ptr_idx_q <= '0;
`endif
                    end
                end
                HDR: begin
                    if (!ioctl_download) begin
                        err     <= 1'b1;
                        state_q <= FIN;
                    end else if (wr_ok_d && ioctl_addr == 23'd0) begin
                        load_q[7:0] <= ioctl_data;
                    end else if (wr_ok_d && ioctl_addr == 23'd1) begin
                        load_q[15:8] <= ioctl_data;
                        state_q      <= DATA;
                    end
                end
                DATA: begin
                    if (!ioctl_download) begin
                        state_q <= EXIT;
                    end else if (wr_ok_d) begin
                        if (wrap_d) begin
                            err <= 1'b1;
                        end else begin
                            ram_addr   <= tgt_d[15:0];
                            ram_dout   <= ioctl_data;
                            ram_we     <= 1'b1;
                            ioctl_wait <= 1'b1;
                            tmo_q      <= '0;
                            state_q    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ok_d) err <= 1'b1;
                    if (ram_ack) begin
                        ram_we     <= 1'b0;
                        ioctl_wait <= 1'b0;
                        end_addr   <= ram_addr + 16'd1;
                        wrote_q    <= 1'b1;
                        state_q    <= DATA;
                    end else if (tmo_hit_d) begin
                        ram_we     <= 1'b0;
                        ioctl_wait <= 1'b0;
                        err        <= 1'b1;
                        state_q    <= DATA;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
`ifdef PRG_BASIC_PTR_EN
                PTR: begin
                    if (!ram_we) begin
                        if (err || !wrote_q || ptr_idx_q == 3'd6) begin
                            state_q <= FIN;
                        end else begin
                            ram_addr <= {8'h00, PTR_BASE + {5'b0, ptr_idx_q}};
                            ram_dout <= ptr_idx_q[0] ? end_addr[15:8] : end_addr[7:0];
                            ram_we   <= 1'b1;
                            tmo_q    <= '0;
                        end
                    end else if (ram_ack) begin
                        ram_we    <= 1'b0;
                        ptr_idx_q <= ptr_idx_q + 3'd1;
                    end else if (tmo_hit_d) begin
                        ram_we <= 1'b0;
                        err    <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
`endif
                FIN: begin
                    done    <= !err;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_ram_injector.sv
// Bench for prg_ram_injector: table vectors, random PRG images and hand-built corner sequences.
// RAM side is a bench responder acking after a programmable latency and logging every write.
module tb_prg_ram_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        load_prg;
    logic [22:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_we;
    logic        ram_ack;
    logic        busy;
    logic        done;
    logic [15:0] end_addr;
    logic        err;

    prg_ram_injector dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .load_prg       (load_prg),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .ioctl_wait     (ioctl_wait),
        .ram_addr       (ram_addr),
        .ram_dout       (ram_dout),
        .ram_we         (ram_we),
        .ram_ack        (ram_ack),
        .busy           (busy),
        .done           (done),
        .end_addr       (end_addr),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        logic [15:0] load;
        int          n;
        int          lat;
        bit          e_err;
        logic [15:0] e_end;
        int          e_wr;
    } vec_t;

    int   nvec = 0;
    int   nbad = 0;
    int   lat_cfg = 0;
    bit   ack_en = 1'b1;
    int   wcnt = 0;
    int   done_cnt = 0;
    int   we_cycles = 0;
    wr_t  wq[$];
    logic [7:0] pay[64];
    int   ptrw = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM arbiter stand-in plus output monitors, all sampled 1 time unit after the edge
    initial begin
        ram_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (ram_we) we_cycles++;
            if (ram_ack) begin
                ram_ack = 1'b0;
            end else if (ram_we && ack_en) begin
                if (wcnt >= lat_cfg) begin
                    ram_ack = 1'b1;
                    wq.push_back('{ram_addr, ram_dout});
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [22:0] a, input logic [7:0] d, input bit honor);
        int t;
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        t = 0;
        while (honor && ioctl_wait && t < 1000) begin
            tick();
            t++;
        end
        if (t >= 1000) check("wait_release", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic begin_session(input int lat, input bit ackon);
        lat_cfg   = lat;
        ack_en    = ackon;
        wq.delete();
        we_cycles = 0;
        done_cnt  = 0;
        ioctl_download = 1'b1;
        load_prg       = 1'b1;
        tick();
    endtask

    task automatic end_session();
        int t;
        ioctl_download = 1'b0;
        load_prg       = 1'b0;
        t = 0;
        while (busy && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) check("busy_release", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic run_session(input logic [15:0] load, input int n, input int lat);
        begin_session(lat, 1'b1);
        send_byte(23'd0, load[7:0], 1'b1);
        send_byte(23'd1, load[15:8], 1'b1);
        for (int i = 0; i < n; i++) send_byte(23'(i + 2), pay[i], 1'b1);
        end_session();
    endtask

    // Reference: payload byte i lands at load+i unless that passes $FFFF
    task automatic verify(input string tag, input logic [15:0] load, input int n);
        wr_t         exp[$];
        bit          e_err;
        int          a;
        logic [15:0] e_end;
        e_err = 1'b0;
        e_end = 16'h0;
        for (int i = 0; i < n; i++) begin
            a = int'(load) + i;
            if (a > 65535) begin
                e_err = 1'b1;
            end else begin
                exp.push_back('{a[15:0], pay[i]});
                e_end = a[15:0] + 16'd1;
            end
        end
`ifdef PRG_BASIC_PTR_EN
        if (!e_err && exp.size() > 0) begin
            for (int j = 0; j < 6; j++) begin
                logic [7:0] pa;
                pa = 8'h2D + 8'(j);
                exp.push_back('{{8'h00, pa}, (j % 2 == 1) ? e_end[15:8] : e_end[7:0]});
            end
        end
`endif
        check({tag, "_nwr"}, 32'(wq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
            check({tag, "_addr"}, 32'(wq[i].a), 32'(exp[i].a));
            check({tag, "_data"}, 32'(wq[i].d), 32'(exp[i].d));
        end
        check({tag, "_err"}, 32'(err), 32'(e_err));
        check({tag, "_done"}, 32'(done_cnt), e_err ? 32'd0 : 32'd1);
        if (exp.size() > 0) check({tag, "_end"}, 32'(end_addr), 32'(e_end));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
    endtask

    initial begin
        vec_t tbl[6];
        logic [15:0] ld;
        int n;

`ifdef PRG_BASIC_PTR_EN
        ptrw = 6;
`endif
        tbl[0] = '{16'h1001, 3, 1, 1'b0, 16'h1004, 3};
        tbl[1] = '{16'hFFFE, 3, 0, 1'b1, 16'h0000, 2};
        tbl[2] = '{16'h1201, 16, 2, 1'b0, 16'h1211, 16};
        tbl[3] = '{16'h0000, 1, 0, 1'b0, 16'h0001, 1};
        tbl[4] = '{16'hFFFF, 1, 3, 1'b0, 16'h0000, 1};
        tbl[5] = '{16'hFFF0, 20, 0, 1'b1, 16'h0000, 16};

        reset = 1'b1;
        ioctl_download = 1'b0;
        load_prg = 1'b0;
        ioctl_addr = '0;
        ioctl_data = '0;
        ioctl_wr = 1'b0;
        tick();
        tick();
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_end", 32'(end_addr), 32'd0);
        check("rst_raddr", 32'(ram_addr), 32'd0);
        check("rst_rdout", 32'(ram_dout), 32'd0);
        reset = 1'b0;
        tick();

        // Basic image 01 10 AA BB CC
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        run_session(16'h1001, 3, 1);
        verify("basic", 16'h1001, 3);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < tbl[k].n; i++) pay[i] = 8'($urandom);
            run_session(tbl[k].load, tbl[k].n, tbl[k].lat);
            check("tbl_err", 32'(err), 32'(tbl[k].e_err));
            check("tbl_end", 32'(end_addr), 32'(tbl[k].e_end));
            check("tbl_nwr", 32'(wq.size()),
                  32'(tbl[k].e_wr + (tbl[k].e_err ? 0 : ptrw)));
            verify("tbl", tbl[k].load, tbl[k].n);
        end

        for (int k = 0; k < 25; k++) begin
            ld = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF4, 16'hFFFF))
                                             : 16'($urandom);
            n  = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
            run_session(ld, n, $urandom_range(0, 3));
            verify("rand", ld, n);
        end

        // Overrun: second strobe while the first write is pending
        begin_session(4, 1'b1);
        send_byte(23'd0, 8'h00, 1'b1);
        send_byte(23'd1, 8'h20, 1'b1);
        send_byte(23'd2, 8'h5A, 1'b0);
        check("ovr_wait", 32'(ioctl_wait), 32'd1);
        send_byte(23'd3, 8'hC3, 1'b1);
        end_session();
        check("ovr_nwr", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) begin
            check("ovr_addr", 32'(wq[0].a), 32'h2000);
            check("ovr_data", 32'(wq[0].d), 32'h5A);
        end
        check("ovr_err", 32'(err), 32'd1);
        check("ovr_end", 32'(end_addr), 32'h2001);
        check("ovr_done", 32'(done_cnt), 32'd0);

        // Download drops in the same cycle the ack arrives
        pay[0] = 8'h11; pay[1] = 8'h22;
        begin_session(0, 1'b1);
        send_byte(23'd0, 8'h00, 1'b1);
        send_byte(23'd1, 8'h30, 1'b1);
        send_byte(23'd2, pay[0], 1'b1);
        send_byte(23'd3, pay[1], 1'b0);
        check("sim_ack", 32'(ram_ack), 32'd1);
        end_session();
        verify("simul", 16'h3000, 2);

        // Image shorter than the header
        begin_session(0, 1'b1);
        send_byte(23'd0, 8'h01, 1'b1);
        end_session();
        check("short_we", 32'(we_cycles), 32'd0);
        check("short_err", 32'(err), 32'd1);
        check("short_done", 32'(done_cnt), 32'd0);
        check("short_busy", 32'(busy), 32'd0);

        // No ack ever: write abandoned after the timeout
        begin_session(0, 1'b0);
        send_byte(23'd0, 8'h00, 1'b1);
        send_byte(23'd1, 8'h40, 1'b1);
        send_byte(23'd2, 8'h77, 1'b1);
        check("tmo_wecyc", 32'(we_cycles), 32'd255);
        check("tmo_wait", 32'(ioctl_wait), 32'd0);
        check("tmo_err", 32'(err), 32'd1);
        end_session();
        check("tmo_done", 32'(done_cnt), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);

        // Reset while a write is pending
        begin_session(0, 1'b0);
        send_byte(23'd0, 8'h00, 1'b1);
        send_byte(23'd1, 8'h50, 1'b1);
        send_byte(23'd2, 8'h99, 1'b0);
        check("mid_we_pre", 32'(ram_we), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("mid_we", 32'(ram_we), 32'd0);
        check("mid_wait", 32'(ioctl_wait), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        ioctl_download = 1'b0;
        load_prg = 1'b0;
        tick();
        reset = 1'b0;
        ack_en = 1'b1;
        tick();

        // Fresh session after the reset still works
        pay[0] = 8'hE1;
        run_session(16'h0400, 1, 1);
        verify("post_rst", 16'h0400, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
